// File: rtl/yuv_plane_packer.sv
// Packs a Y/U/V pixel stream into little-endian planar words (Y, then U, then V)
// with 4:2:0 or 4:2:2 chroma decimation and a backpressured word-write port.
module yuv_plane_packer #(
    parameter int unsigned IMG_W      = 640,
    parameter int unsigned IMG_H      = 480,
    parameter int unsigned WORD_BYTES = 8,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                    PIXEL_CLK,
    input  logic                    RESET,
    input  logic                    chroma_mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sof,
    input  logic [7:0]              in_y,
    input  logic [7:0]              in_u,
    input  logic [7:0]              in_v,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [8*WORD_BYTES-1:0] wr_data,
    output logic [ADDR_W-1:0]       wr_address,
    output logic                    frame_done,
    output logic                    sof_error
);

    localparam int unsigned COL_W  = $clog2(IMG_W);
    localparam int unsigned ROW_W  = $clog2(IMG_H);
    localparam int unsigned BW     = $clog2(WORD_BYTES);
    localparam int unsigned DW     = 8 * WORD_BYTES;
    localparam int unsigned Y_SIZE = IMG_W * IMG_H / WORD_BYTES;
    localparam int unsigned C420   = IMG_W * IMG_H / (4 * WORD_BYTES);
    localparam int unsigned C422   = IMG_W * IMG_H / (2 * WORD_BYTES);

    localparam logic [ADDR_W-1:0] Y_BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] U_BASE     = ADDR_W'(BASE_ADDR + Y_SIZE);
    localparam logic [ADDR_W-1:0] V_BASE_420 = ADDR_W'(BASE_ADDR + Y_SIZE + C420);
    localparam logic [ADDR_W-1:0] V_BASE_422 = ADDR_W'(BASE_ADDR + Y_SIZE + C422);
    localparam logic [BW-1:0]     LAST_B     = BW'(WORD_BYTES - 1);
    localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(IMG_H - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

    state_t              state_q;
    logic [COL_W-1:0]    col_q;
    logic [ROW_W-1:0]    row_q;
    logic                mode_q;
    logic [DW-1:0]       y_asm_q, u_asm_q, v_asm_q;
    logic [DW-1:0]       y_hold_q, u_hold_q, v_hold_q;
    logic [ADDR_W-1:0]   y_addr_q, u_addr_q, v_addr_q;
    logic                pend_y_q, pend_u_q, pend_v_q;
    logic [ADDR_W-1:0]   ycnt_q, ucnt_q, vcnt_q;
    logic [2:0]          done_mask_q;
    logic                lock_q;
    logic [2:0]          lock_sel_q;
    logic                sof_error_q;

    logic                acc, active, last, mode_eff;
    logic [COL_W-1:0]    pos_col;
    logic [ROW_W-1:0]    pos_row;
    logic                y_done, c_samp, c_done;
    logic [DW-1:0]       y_word, u_word, v_word;
    logic [ADDR_W-1:0]   ycnt_eff, ucnt_eff, vcnt_eff, v_base;
    logic [2:0]          sel, hs_mask, done_mask_d;
    logic                pend_y_d, pend_u_d, pend_v_d;
    logic                y_would, c_would;

    // Stall decisions look only at registered state, so in_ready has no input path.
    assign y_would  = (state_q == StRun) && (col_q[BW-1:0] == LAST_B) && pend_y_q;
    assign c_would  = (state_q == StRun) && !col_q[0] && (mode_q || !row_q[0]) &&
                      (col_q[BW:1] == LAST_B) && (pend_u_q || pend_v_q);
    assign in_ready = !y_would && !c_would;

    assign acc      = in_valid && in_ready;
    assign active   = acc && (in_sof || state_q == StRun);
    assign pos_col  = in_sof ? '0 : col_q;
    assign pos_row  = in_sof ? '0 : row_q;
    assign mode_eff = in_sof ? chroma_mode : mode_q;
    assign last     = active && (pos_col == LAST_COL) && (pos_row == LAST_ROW);
    assign y_done   = active && (pos_col[BW-1:0] == LAST_B);
    assign c_samp   = active && !pos_col[0] && (mode_eff || !pos_row[0]);
    assign c_done   = c_samp && (pos_col[BW:1] == LAST_B);
    assign ycnt_eff = in_sof ? '0 : ycnt_q;
    assign ucnt_eff = in_sof ? '0 : ucnt_q;
    assign vcnt_eff = in_sof ? '0 : vcnt_q;
    assign v_base   = mode_eff ? V_BASE_422 : V_BASE_420;

    always_comb begin
        y_word = y_asm_q;
        u_word = u_asm_q;
        v_word = v_asm_q;
        y_word[{pos_col[BW-1:0], 3'b000} +: 8] = in_y;
        u_word[{pos_col[BW:1], 3'b000} +: 8]   = in_u;
        v_word[{pos_col[BW:1], 3'b000} +: 8]   = in_v;
    end

    // A stalled word stays selected even if a higher-priority plane becomes pending.
    always_comb begin
        sel = 3'b000;
        if (lock_q)        sel = lock_sel_q;
        else if (pend_y_q) sel = 3'b001;
        else if (pend_u_q) sel = 3'b010;
        else if (pend_v_q) sel = 3'b100;
    end

    always_comb begin
        wr_data    = '0;
        wr_address = '0;
        unique case (sel)
            3'b001:  begin wr_data = y_hold_q; wr_address = y_addr_q; end
            3'b010:  begin wr_data = u_hold_q; wr_address = u_addr_q; end
            3'b100:  begin wr_data = v_hold_q; wr_address = v_addr_q; end
            default: ;
        endcase
    end

    assign wr_valid    = |sel;
    assign hs_mask     = sel & {3{wr_ready}};
    assign pend_y_d    = y_done || (pend_y_q && !hs_mask[0]);
    assign pend_u_d    = c_done || (pend_u_q && !hs_mask[1]);
    assign pend_v_d    = c_done || (pend_v_q && !hs_mask[2]);
    assign done_mask_d = last ? {pend_v_d, pend_u_d, pend_y_d} : (done_mask_q & ~hs_mask);
    assign frame_done  = |(done_mask_q & hs_mask) && !(|(done_mask_q & ~hs_mask));
    assign sof_error   = sof_error_q;

    always_ff @(posedge PIXEL_CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= StIdle;
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= 1'b0;
            y_asm_q     <= '0;
            u_asm_q     <= '0;
            v_asm_q     <= '0;
            y_hold_q    <= '0;
            u_hold_q    <= '0;
            v_hold_q    <= '0;
            y_addr_q    <= '0;
            u_addr_q    <= '0;
            v_addr_q    <= '0;
            pend_y_q    <= 1'b0;
            pend_u_q    <= 1'b0;
            pend_v_q    <= 1'b0;
            ycnt_q      <= '0;
            ucnt_q      <= '0;
            vcnt_q      <= '0;
            done_mask_q <= '0;
            lock_q      <= 1'b0;
            lock_sel_q  <= '0;
            sof_error_q <= 1'b0;
        end else begin
            lock_q      <= wr_valid && !wr_ready;
            lock_sel_q  <= sel;
            sof_error_q <= acc && in_sof && (state_q == StRun) && (col_q != '0 || row_q != '0);
            done_mask_q <= done_mask_d;
            pend_y_q    <= pend_y_d;
            pend_u_q    <= pend_u_d;
            pend_v_q    <= pend_v_d;
            if (active) begin
                y_asm_q <= y_word;
                if (in_sof) mode_q <= chroma_mode;
                if (pos_col == LAST_COL) begin
                    col_q <= '0;
                    row_q <= (pos_row == LAST_ROW) ? '0 : pos_row + ROW_W'(1);
                end else begin
                    col_q <= pos_col + COL_W'(1);
                    row_q <= pos_row;
                end
                ycnt_q <= y_done ? ycnt_eff + ADDR_W'(1) : ycnt_eff;
                ucnt_q <= c_done ? ucnt_eff + ADDR_W'(1) : ucnt_eff;
                vcnt_q <= c_done ? vcnt_eff + ADDR_W'(1) : vcnt_eff;
            end
            if (c_samp) begin
                u_asm_q <= u_word;
                v_asm_q <= v_word;
            end
            if (y_done) begin
                y_hold_q <= y_word;
                y_addr_q <= Y_BASE + ycnt_eff;
            end
            if (c_done) begin
                u_hold_q <= u_word;
                v_hold_q <= v_word;
                u_addr_q <= U_BASE + ucnt_eff;
                v_addr_q <= v_base + vcnt_eff;
            end
            unique case (state_q)
                StIdle:  if (active) state_q <= StRun;
                StRun:   if (last) state_q <= StDrain;
                StDrain: begin
                    if (active)                  state_q <= StRun;
                    else if (done_mask_d == '0)  state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_yuv_plane_packer.sv
// Bench for yuv_plane_packer on a 16x4 frame with 4-byte words: per-plane expected
// write queues filled from the pixel pattern, plus a table of full-frame cases.
module tb_yuv_plane_packer;

    localparam int unsigned IMG_W = 16;
    localparam int unsigned IMG_H = 4;
    localparam int unsigned WB    = 4;
    localparam int unsigned AW    = 16;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        bit          mode;
        bit          toggle;
        int          n_writes;
        int          n_done;
        int          chk_addr;
        logic [31:0] chk_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        chroma_mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sof = 1'b0;
    logic [7:0]  in_y = '0, in_u = '0, in_v = '0;
    logic        wr_valid;
    logic        wr_ready = 1'b1;
    logic [31:0] wr_data;
    logic [15:0] wr_address;
    logic        frame_done;
    logic        sof_error;

    always #5 clk = ~clk;

    yuv_plane_packer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .WORD_BYTES(WB), .ADDR_W(AW), .BASE_ADDR(0)
    ) dut (
        .PIXEL_CLK(clk), .RESET(rst), .chroma_mode(chroma_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_y(in_y), .in_u(in_u), .in_v(in_v),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .wr_address(wr_address), .frame_done(frame_done), .sof_error(sof_error)
    );

    int compared = 0;
    int mismatched = 0;
    int n_wr, n_done, n_serr, n_stall, cur_idx;
    bit tb_mode;
    wr_t yq[$], uq[$], vq[$];
    logic [15:0] wlog[$];
    logic [31:0] seen[int];
    wr_t mon_got, mon_exp;
    int  mon_plane, mon_cs;
    bit  mon_have;
    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pv(input int idx, input logic [7:0] off);
        return 8'(idx) + off;
    endfunction

    // Expected words for the first n pixels of a frame; a word counts only if its last pixel is in.
    function automatic void push_expect(input bit mode, input logic [7:0] off, input int n);
        wr_t e;
        int  cs, seq, lastp;
        cs  = mode ? 8 : 4;
        seq = 0;
        for (int k = 0; k < 16; k++) begin
            if (4 * k + 3 < n) begin
                e.a = 16'(k);
                for (int j = 0; j < 4; j++) e.d[8*j +: 8] = pv(4 * k + j, off);
                yq.push_back(e);
            end
        end
        for (int r = 0; r < 4; r++) begin
            if (mode || (r % 2 == 0)) begin
                for (int w = 0; w < 2; w++) begin
                    lastp = r * 16 + 8 * w + 6;
                    if (lastp < n) begin
                        e.a = 16'(16 + seq);
                        for (int j = 0; j < 4; j++) e.d[8*j +: 8] = pv(r * 16 + 8 * w + 2 * j, off);
                        uq.push_back(e);
                        e.a = 16'(16 + cs + seq);
                        for (int j = 0; j < 4; j++)
                            e.d[8*j +: 8] = pv(r * 16 + 8 * w + 2 * j, off) + 8'h80;
                        vq.push_back(e);
                        seq++;
                    end
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_valid && wr_ready) begin
                n_wr++;
                wlog.push_back(wr_address);
                seen[int'(wr_address)] = wr_data;
                mon_got.a = wr_address;
                mon_got.d = wr_data;
                mon_cs    = tb_mode ? 8 : 4;
                mon_plane = (wr_address < 16) ? 0 : (int'(wr_address) < 16 + mon_cs) ? 1 : 2;
                case (mon_plane)
                    0:       mon_have = yq.size() > 0;
                    1:       mon_have = uq.size() > 0;
                    default: mon_have = vq.size() > 0;
                endcase
                if (!mon_have) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_write: got addr %0d data %h, required no write",
                             wr_address, wr_data);
                end else begin
                    case (mon_plane)
                        0:       mon_exp = yq.pop_front();
                        1:       mon_exp = uq.pop_front();
                        default: mon_exp = vq.pop_front();
                    endcase
                    check("write_addr_data", 64'(mon_got), 64'(mon_exp));
                end
            end
            if (frame_done) n_done++;
            if (sof_error) n_serr++;
            if (in_valid && !in_ready) n_stall++;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        n_wr = 0; n_done = 0; n_serr = 0; n_stall = 0;
        yq.delete(); uq.delete(); vq.delete(); wlog.delete(); seen.delete();
    endtask

    task automatic send_pixel(input bit sof, input int idx, input logic [7:0] off);
        bit ok;
        in_valid = 1'b1;
        in_sof   = sof;
        in_y     = pv(idx, off);
        in_u     = pv(idx, off);
        in_v     = pv(idx, off) + 8'h80;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: pixel %0d not accepted, required acceptance", idx);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_range(input bit mode, input bit toggle, input logic [7:0] off,
                              input int start, input int stop, input bit sof_first);
        for (int i = start; i < stop; i++) begin
            cur_idx     = i;
            chroma_mode = (toggle && i >= 20) ? ~mode : mode;
            send_pixel(sof_first && (i == start), i, off);
        end
    endtask

    task automatic wait_idle();
        int quiet;
        quiet = 0;
        for (int t = 0; t < 400 && quiet < 4; t++) begin
            @(negedge clk);
            if (wr_valid) quiet = 0;
            else quiet++;
        end
        check("drain_done", 64'(quiet >= 4), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stalled;
        vecs[0] = '{mode: 1'b0, toggle: 1'b0, n_writes: 24, n_done: 1, chk_addr: 16,
                    chk_data: 32'h06040200};
        vecs[1] = '{mode: 1'b1, toggle: 1'b0, n_writes: 32, n_done: 1, chk_addr: 18,
                    chk_data: 32'h16141210};
        vecs[2] = '{mode: 1'b0, toggle: 1'b1, n_writes: 24, n_done: 1, chk_addr: 20,
                    chk_data: 32'h86848280};
        vecs[3] = '{mode: 1'b1, toggle: 1'b1, n_writes: 32, n_done: 1, chk_addr: 26,
                    chk_data: 32'h96949290};
        clear();
        tb_mode = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_wr_valid", 64'(wr_valid), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_wr_address", 64'(wr_address), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_sof_error", 64'(sof_error), 64'd0);
        sync();
        rst = 1'b0;

        // Full frames with wr_ready high, including mode changes after sof.
        for (int v = 0; v < 4; v++) begin
            sync();
            clear();
            tb_mode = vecs[v].mode;
            push_expect(vecs[v].mode, 8'h00, 64);
            send_range(vecs[v].mode, vecs[v].toggle, 8'h00, 0, 64, 1'b1);
            wait_idle();
            check("frame_writes", 64'(n_wr), 64'(vecs[v].n_writes));
            check("frame_done_count", 64'(n_done), 64'(vecs[v].n_done));
            check("frame_chk_data",
                  64'(seen.exists(vecs[v].chk_addr) ? seen[vecs[v].chk_addr] : 32'hxxxxxxxx),
                  64'(vecs[v].chk_data));
            check("frame_no_stall", 64'(n_stall), 64'd0);
            check("frame_leftover", 64'(yq.size() + uq.size() + vq.size()), 64'd0);
            check("frame_no_sof_error", 64'(n_serr), 64'd0);
        end

        // Sink blocked from the first pixel.
        sync();
        clear();
        tb_mode  = 1'b0;
        wr_ready = 1'b0;
        push_expect(1'b0, 8'h00, 64);
        fork
            send_range(1'b0, 1'b0, 8'h00, 0, 64, 1'b1);
            begin
                stalled = 1'b0;
                for (int t = 0; t < 100; t++) begin
                    @(negedge clk);
                    if (in_valid && !in_ready) begin
                        stalled = 1'b1;
                        break;
                    end
                end
                check("bp_stall_seen", 64'(stalled), 64'd1);
                check("bp_stall_pixel", 64'(cur_idx), 64'd7);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("bp_hold_valid", 64'(wr_valid), 64'd1);
                    check("bp_hold_addr", 64'(wr_address), 64'd0);
                    check("bp_hold_data", 64'(wr_data), 64'h03020100);
                end
                sync();
                wr_ready = 1'b1;
            end
        join
        wait_idle();
        check("bp_writes", 64'(n_wr), 64'd24);
        check("bp_order0", 64'(wlog.size() > 0 ? wlog[0] : 16'hffff), 64'd0);
        check("bp_order1", 64'(wlog.size() > 1 ? wlog[1] : 16'hffff), 64'd16);
        check("bp_order2", 64'(wlog.size() > 2 ? wlog[2] : 16'hffff), 64'd1);
        check("bp_order3", 64'(wlog.size() > 3 ? wlog[3] : 16'hffff), 64'd20);
        check("bp_leftover", 64'(yq.size() + uq.size() + vq.size()), 64'd0);
        check("bp_done", 64'(n_done), 64'd1);

        // Restart in the middle of a frame.
        sync();
        clear();
        tb_mode = 1'b0;
        push_expect(1'b0, 8'h00, 21);
        push_expect(1'b0, 8'h40, 64);
        send_range(1'b0, 1'b0, 8'h00, 0, 21, 1'b1);
        send_range(1'b0, 1'b0, 8'h40, 0, 64, 1'b1);
        wait_idle();
        check("sof_err_pulses", 64'(n_serr), 64'd1);
        check("sof_err_done", 64'(n_done), 64'd1);
        check("sof_err_writes", 64'(n_wr), 64'd33);
        check("sof_err_leftover", 64'(yq.size() + uq.size() + vq.size()), 64'd0);
        check("sof_err_new_y0", 64'(seen.exists(0) ? seen[0] : 32'hxxxxxxxx), 64'h43424140);

        // Reset with words pending, then pixels without sof are ignored.
        sync();
        clear();
        tb_mode  = 1'b0;
        wr_ready = 1'b0;
        send_range(1'b0, 1'b0, 8'h00, 0, 7, 1'b1);
        @(negedge clk);
        check("rst_pre_valid", 64'(wr_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_valid", 64'(wr_valid), 64'd0);
        check("rst_mid_addr", 64'(wr_address), 64'd0);
        check("rst_mid_ready", 64'(in_ready), 64'd1);
        sync();
        rst      = 1'b0;
        wr_ready = 1'b1;
        send_range(1'b0, 1'b0, 8'h00, 7, 30, 1'b0);
        repeat (10) @(negedge clk);
        check("rst_no_writes", 64'(n_wr), 64'd0);
        sync();
        clear();
        tb_mode = 1'b1;
        push_expect(1'b1, 8'h20, 64);
        send_range(1'b1, 1'b0, 8'h20, 0, 64, 1'b1);
        wait_idle();
        check("rst_recover_writes", 64'(n_wr), 64'd32);
        check("rst_recover_done", 64'(n_done), 64'd1);
        check("rst_recover_leftover", 64'(yq.size() + uq.size() + vq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
